// File: rtl/kcore_fifo_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : kcore_arb_pkg
//  Purpose  : Shared types, constants and helpers for the kcore FIFO
//             round-robin arbiter slice.
//  Contents : kcore_id_width()  - minimum source-tag width for N sources
//             arb_state_t       - arbiter state encoding (ST_IDLE/ST_SERVE)
//             c_burst_w         - width of the per-grant beat counter
//             c_beat_w          - width of the total beat counter
//  Revision : 1.0 - initial release
// ============================================================================
package kcore_arb_pkg;

  localparam int c_burst_w = 8;
  localparam int c_beat_w  = 32;

  // One-bit state register; the arbiter is either hunting for a source
  // (IDLE) or streaming a burst from the current owner (SERVE).
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SERVE = 1'b1
  } arb_state_t;

  // ceil(log2(n)), but never less than one bit so a tag always exists.
  function automatic int kcore_id_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage : kcore_arb_pkg
`default_nettype wire

// File: rtl/kcore_fifo_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : kcore_fifo_rr_arbiter_if
//  Purpose  : Bundles the N upstream show-ahead FIFO read ports and the one
//             downstream FIFO write port seen by the arbiter.
//  Signals  : src_empty_n [N_SRC]            per-source data available
//             src_read    [N_SRC]            per-source pop strobe
//             src_dout    [N_SRC*DATA_WIDTH] source i at [i*DATA_WIDTH +: DATA_WIDTH]
//             out_full_n                     downstream can accept
//             out_write                      downstream write strobe
//             out_din     [ID+DATA]          {src_id, payload}
//  Modports : master - the arbiter; slave - the FIFOs around it
//  Revision : 1.0 - initial release
// ============================================================================
interface kcore_fifo_rr_arbiter_if
  import kcore_arb_pkg::*;
#(
  parameter int N_SRC      = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = kcore_id_width(N_SRC)
);

  logic [N_SRC-1:0]            src_empty_n;
  logic [N_SRC-1:0]            src_read;
  logic [N_SRC*DATA_WIDTH-1:0] src_dout;
  logic                        out_full_n;
  logic                        out_write;
  logic [ID_WIDTH+DATA_WIDTH-1:0] out_din;

  modport master (
    input  src_empty_n,
    input  src_dout,
    input  out_full_n,
    output src_read,
    output out_write,
    output out_din
  );

  modport slave (
    output src_empty_n,
    output src_dout,
    output out_full_n,
    input  src_read,
    input  out_write,
    input  out_din
  );

endinterface : kcore_fifo_rr_arbiter_if
`default_nettype wire

// File: rtl/kcore_fifo_rr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : kcore_rr_pick
//  Purpose  : Combinational circular first-one finder.
//  Ports    : i_req        request vector
//             i_start      index where the circular scan begins
//             i_skip_start when 1 the scan begins at i_start+1 and i_start
//                          itself is tested last
//             o_idx        index of the first set request found
//             o_valid      at least one request is set
//  Revision : 1.0 - initial release
// ============================================================================
module kcore_rr_pick
  import kcore_arb_pkg::*;
#(
  parameter int N_SRC    = 4,
  parameter int ID_WIDTH = kcore_id_width(N_SRC)
) (
  input  wire logic [N_SRC-1:0]    i_req,
  input  wire logic [ID_WIDTH-1:0] i_start,
  input  wire logic                i_skip_start,
  output logic      [ID_WIDTH-1:0] o_idx,
  output logic                     o_valid
);

  int   w_pos;
  logic w_hit;

  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_pos   = 0;
    w_hit   = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      w_pos = (int'(i_start) + k + (i_skip_start ? 1 : 0)) % N_SRC;
      w_hit = |(i_req & (N_SRC'(1) << w_pos));
      if (!o_valid && w_hit) begin
        o_valid = 1'b1;
        o_idx   = ID_WIDTH'(w_pos);
      end
    end
  end

endmodule : kcore_rr_pick
`default_nettype wire

// File: rtl/kcore_fifo_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : kcore_fifo_rr_arbiter
//  Purpose  : Shares one downstream kcore FIFO write port among N_SRC
//             show-ahead upstream FIFOs. Round-robin with a per-grant burst
//             cap of MAX_BURST beats; every beat is tagged with its source.
//  Ports    : clk        clock
//             reset_n    synchronous active-low reset
//             enable     0 stops new pops, the output register still drains
//             bus        kcore_fifo_rr_arbiter_if.master (FIFO side signals)
//             busy       SERVE state or output register holding a beat
//             beat_count total beats accepted, wraps at 2^32
//  Revision : 1.0 - initial release
// ============================================================================
module kcore_fifo_rr_arbiter
  import kcore_arb_pkg::*;
#(
  parameter int N_SRC      = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = kcore_id_width(N_SRC),
  parameter int MAX_BURST  = 8
) (
  input  wire logic                clk,
  input  wire logic                reset_n,
  input  wire logic                enable,
  kcore_fifo_rr_arbiter_if.master  bus,
  output logic                     busy,
  output logic [c_beat_w-1:0]      beat_count
);

  localparam logic [c_burst_w-1:0] c_max_burst = c_burst_w'(MAX_BURST);
  localparam logic [ID_WIDTH-1:0]  c_last_src  = ID_WIDTH'(N_SRC - 1);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  arb_state_t                     r_state;
  logic [ID_WIDTH-1:0]            r_cur;
  logic [ID_WIDTH-1:0]            r_rr_ptr;
  logic [c_burst_w-1:0]           r_burst_cnt;
  logic                           r_stage_valid;
  logic [ID_WIDTH+DATA_WIDTH-1:0] r_stage_data;
  logic [c_beat_w-1:0]            r_beat_count;

  // --------------------------------------------------------------------------
  // Combinational
  // --------------------------------------------------------------------------
  arb_state_t            w_state_nxt;
  logic [ID_WIDTH-1:0]   w_cur_nxt;
  logic [ID_WIDTH-1:0]   w_rr_ptr_nxt;
  logic [c_burst_w-1:0]  w_burst_nxt;
  logic                  w_stage_valid_nxt;

  logic                  w_stage_ready;
  logic                  w_cur_req;
  logic                  w_continue;
  logic [ID_WIDTH-1:0]   w_pick_start;
  logic                  w_pick_skip;
  logic [ID_WIDTH-1:0]   w_pick_idx;
  logic                  w_pick_valid;
  logic [ID_WIDTH-1:0]   w_grant_idx;
  logic                  w_grant_valid;
  logic                  w_pop;
  logic [N_SRC-1:0]      w_src_read;
  logic [DATA_WIDTH-1:0] w_sel_data;

  // The output register can take a new beat when empty or when the beat it
  // holds is being written this cycle.
  assign w_stage_ready = !r_stage_valid | bus.out_full_n;

  assign w_cur_req  = |(bus.src_empty_n & (N_SRC'(1) << r_cur));
  assign w_continue = (r_state == ST_SERVE) && w_cur_req && (r_burst_cnt < c_max_burst);

  // IDLE scans from the round-robin pointer. In SERVE the scan starts after
  // the current owner, so the owner is only re-granted when nobody else asks.
  assign w_pick_start = (r_state == ST_SERVE) ? r_cur : r_rr_ptr;
  assign w_pick_skip  = (r_state == ST_SERVE);

  kcore_rr_pick #(
    .N_SRC    (N_SRC),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .i_req        (bus.src_empty_n),
    .i_start      (w_pick_start),
    .i_skip_start (w_pick_skip),
    .o_idx        (w_pick_idx),
    .o_valid      (w_pick_valid)
  );

  assign w_grant_idx   = w_continue ? r_cur : w_pick_idx;
  assign w_grant_valid = w_continue | w_pick_valid;

  // reset_n gates the pop so no FIFO is drained in a reset cycle.
  assign w_pop = reset_n & enable & w_stage_ready & w_grant_valid;

  always_comb begin
    w_src_read = '0;
    w_sel_data = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (w_grant_idx == ID_WIDTH'(i)) begin
        w_src_read[i] = w_pop;
        w_sel_data    = bus.src_dout[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state / arbitration bookkeeping.
  always_comb begin
    w_state_nxt  = r_state;
    w_cur_nxt    = r_cur;
    w_rr_ptr_nxt = r_rr_ptr;
    w_burst_nxt  = r_burst_cnt;
    if (w_pop) begin
      w_state_nxt  = ST_SERVE;
      w_cur_nxt    = w_grant_idx;
      // A fresh grant, or the owner winning again after hitting the cap,
      // starts a new burst.
      w_burst_nxt  = w_continue ? (r_burst_cnt + c_burst_w'(1)) : c_burst_w'(1);
      w_rr_ptr_nxt = (w_grant_idx == c_last_src) ? '0 : (w_grant_idx + ID_WIDTH'(1));
    end else if ((r_state == ST_SERVE) && w_stage_ready && enable && !w_grant_valid) begin
      w_state_nxt = ST_IDLE;
      w_burst_nxt = '0;
    end
  end

  always_comb begin
    w_stage_valid_nxt = r_stage_valid;
    if (w_pop) begin
      w_stage_valid_nxt = 1'b1;
    end else if (bus.out_full_n) begin
      w_stage_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_cur         <= '0;
      r_rr_ptr      <= '0;
      r_burst_cnt   <= '0;
      r_stage_valid <= 1'b0;
      r_stage_data  <= '0;
      r_beat_count  <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cur         <= w_cur_nxt;
      r_rr_ptr      <= w_rr_ptr_nxt;
      r_burst_cnt   <= w_burst_nxt;
      r_stage_valid <= w_stage_valid_nxt;
      if (w_pop) begin
        r_stage_data <= {w_grant_idx, w_sel_data};
        r_beat_count <= r_beat_count + c_beat_w'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.src_read  = w_src_read;
  assign bus.out_write = r_stage_valid;
  assign bus.out_din   = r_stage_data;
  assign busy          = (r_state == ST_SERVE) | r_stage_valid;
  assign beat_count    = r_beat_count;

endmodule : kcore_fifo_rr_arbiter
`default_nettype wire
